// File: rtl/fetch_pkg.sv
// Shared types and constants for the program-counter / instruction-fetch controller.
package fetch_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    SETTLE,
    REQ,
    WAIT,
    HOLD,
    REDIR
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl.sv
// PC sequencing and single-entry instruction fetch buffer. It works with an external
// registered pc+4 incrementer and handles branch/jump redirects.
//
// state  | meaning
// SETTLE | pc_out just changed; incrementer captures it on this edge
// REQ    | imem_req high, waiting for imem_gnt
// WAIT   | request accepted, waiting for imem_rvalid
// HOLD   | instruction buffered, inst_valid high until decode takes it
// REDIR  | stale response dropped, load the latched redirect target
module pc_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic [WORD_W-1:0] pc_out,
  input  logic [WORD_W-1:0] pc_inc_in,
  output logic              imem_req,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] inst_out,
  output logic [WORD_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  fetch_count
);

  fetch_state_e      state;
  logic              redir_pend;
  logic [WORD_W-1:0] redir_tgt;
  logic [WORD_W-1:0] redirect_aligned;

  assign redirect_aligned = redirect_pc & PC_ALIGN_MASK;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= SETTLE;
      pc_out       <= RESET_PC;
      imem_req     <= 1'b0;
      inst_valid   <= 1'b0;
      inst_out     <= '0;
      inst_pc      <= '0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
      redir_pend   <= 1'b0;
      redir_tgt    <= '0;
    end else begin
      if (redirect) begin
        redir_tgt  <= redirect_aligned;
        redir_pend <= 1'b1;
        if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
      end

      // Assignments below deliberately override the redirect capture above
      // when the redirect is consumed in the same cycle.
      case (state)
        SETTLE: begin
          imem_req <= 1'b1;
          state    <= REQ;
        end
        REQ: begin
          if (imem_gnt) begin
            imem_req <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (redirect || redir_pend) begin
              state <= REDIR;
            end else begin
              inst_out   <= imem_rdata;
              inst_pc    <= pc_out;
              inst_valid <= 1'b1;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (inst_ready) begin
            fetch_count <= fetch_count + {{(CNT_W-1){1'b0}}, 1'b1};
            inst_valid  <= 1'b0;
            redir_pend  <= 1'b0;
            if (redirect)        pc_out <= redirect_aligned;
            else if (redir_pend) pc_out <= redir_tgt;
            else                 pc_out <= pc_inc_in;
            state <= SETTLE;
          end
        end
        REDIR: begin
          pc_out     <= redirect ? redirect_aligned : redir_tgt;
          redir_pend <= 1'b0;
          state      <= SETTLE;
        end
        default: state <= SETTLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios followed by random traffic, checked
// against a program-flow model of the expected instruction stream.
module tb_pc_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_out, pc_inc, imem_rdata, inst_out, inst_pc, redirect_pc, fetch_count;
  logic        imem_req, imem_gnt, imem_rvalid, inst_valid, inst_ready, redirect, misalign_err;

  pc_fetch_ctrl #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .pc_out(pc_out), .pc_inc_in(pc_inc),
    .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_out(inst_out), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .misalign_err(misalign_err),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // external registered incrementer
  always @(posedge clk) pc_inc <= pc_out + 32'd4;

  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned m_count;
  logic        m_mis, m_redir;
  logic [31:0] m_tgt, m_last;

  logic        resp_pend;
  logic [31:0] resp_addr;
  int          gnt_pct = 100;
  int          rv_pct  = 100;
  logic        got_grant;
  logic [31:0] grant_addr;
  logic [31:0] req_q[$];

  logic        p_req, p_gnt, p_rvalid, p_valid, p_ready, p_redir;
  logic [31:0] p_rpc, p_pc, p_out, p_ipc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hAAAA_0000 + a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_mis   = 1'b0;
    m_redir = 1'b0;
    m_tgt   = '0;
    m_last  = RST_PC - 32'd4;
  endtask

  task automatic mem_drive();
    imem_gnt = imem_req && (int'($urandom_range(0, 99)) < gnt_pct);
    if (resp_pend && (int'($urandom_range(0, 99)) < rv_pct)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(resp_addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  // One clock: drive memory, clock, then update the model and check outputs.
  task automatic cyc();
    logic [31:0] exp_pc;
    mem_drive();
    p_req = imem_req;   p_gnt = imem_gnt;     p_rvalid = imem_rvalid;
    p_valid = inst_valid; p_ready = inst_ready; p_redir = redirect;
    p_rpc = redirect_pc; p_pc = pc_out; p_out = inst_out; p_ipc = inst_pc;
    @(posedge clk); #1;
    got_grant = 1'b0;
    if (p_rvalid) resp_pend = 1'b0;
    if (p_req && p_gnt) begin
      resp_pend  = 1'b1;
      resp_addr  = p_pc;
      got_grant  = 1'b1;
      grant_addr = p_pc;
      req_q.push_back(p_pc);
    end
    if (p_redir) begin
      m_redir = 1'b1;
      m_tgt   = p_rpc & PC_ALIGN_MASK;
      if (p_rpc[1:0] != 2'b00) m_mis = 1'b1;
    end
    if (p_valid && p_ready) m_count++;
    if (p_valid && !p_ready) begin
      chk("stall_valid", inst_valid, 32'd1);
      chk("stall_inst", inst_out, p_out);
      chk("stall_pc", inst_pc, p_ipc);
    end else if (inst_valid) begin
      exp_pc = m_redir ? m_tgt : m_last + 32'd4;
      chk("stream_pc", inst_pc, exp_pc);
      chk("stream_inst", inst_out, mem_word(exp_pc));
      m_last  = exp_pc;
      m_redir = 1'b0;
    end
    chk("fetch_count", fetch_count, m_count);
    chk("misalign_err", misalign_err, m_mis);
    @(negedge clk);
  endtask

  task automatic wait_grant(input string tag, input logic [31:0] exp_addr, input bit no_valid);
    int n = 0;
    do begin
      cyc();
      n++;
      if (no_valid) chk({tag, "_novalid"}, inst_valid, 32'd0);
    end while (!got_grant && n < 50);
    chk({tag, "_addr"}, got_grant ? grant_addr : 32'hDEAD_BEEF, exp_addr);
  endtask

  task automatic wait_hold(input string tag);
    int n = 0;
    while (!inst_valid && n < 50) begin
      cyc();
      n++;
    end
    chk({tag, "_valid"}, inst_valid, 32'd1);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    resp_pend = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc_out, RST_PC);
    chk("rst_req", imem_req, 32'd0);
    chk("rst_valid", inst_valid, 32'd0);
    chk("rst_inst", inst_out, 32'd0);
    chk("rst_ipc", inst_pc, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_mis", misalign_err, 32'd0);
    rst = 1'b0;
    model_reset();
    req_q.delete();
  endtask

  initial begin
    #1;
    apply_reset();

    // sequential fetch
    repeat (12) cyc();
    chk("seq_count", fetch_count, 32'd3);
    chk("seq_nreq", req_q.size(), 32'd3);
    if (req_q.size() >= 3) begin
      chk("seq_a0", req_q[0], 32'h100);
      chk("seq_a1", req_q[1], 32'h104);
      chk("seq_a2", req_q[2], 32'h108);
    end

    // backpressure in HOLD at 0x104
    apply_reset();
    repeat (4) cyc();
    inst_ready = 1'b0;
    wait_hold("bp_hold");
    chk("bp_pc0", inst_pc, 32'h104);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_pc", inst_pc, 32'h104);
      chk("bp_inst", inst_out, 32'hAAAA_0104);
      chk("bp_noreq", imem_req, 32'd0);
      chk("bp_count", fetch_count, 32'd1);
    end
    inst_ready = 1'b1;
    wait_grant("bp_next", 32'h108, 1'b0);

    // redirect on the handshake cycle
    wait_hold("rh_hold");
    redirect = 1'b1; redirect_pc = 32'h2000;
    cyc();
    redirect = 1'b0;
    wait_grant("rh", 32'h2000, 1'b0);

    // redirect while waiting for read data
    rv_pct = 0;
    redirect = 1'b1; redirect_pc = 32'h3000;
    cyc();
    redirect = 1'b0;
    rv_pct = 100;
    wait_grant("rw", 32'h3000, 1'b1);

    // misaligned target, then wrap at top of address space
    wait_hold("mis_hold");
    redirect = 1'b1; redirect_pc = 32'h4002;
    cyc();
    redirect = 1'b0;
    chk("mis_flag", misalign_err, 32'd1);
    wait_grant("mis", 32'h4000, 1'b0);
    wait_hold("wrap_hold0");
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect = 1'b0;
    wait_grant("wrap_tgt", 32'hFFFF_FFFC, 1'b0);
    wait_hold("wrap_hold1");
    chk("wrap_ipc", inst_pc, 32'hFFFF_FFFC);
    rv_pct = 0;
    wait_grant("wrap_seq", 32'h0, 1'b0);
    chk("mis_sticky", misalign_err, 32'd1);

    // asynchronous reset while in WAIT, late response afterwards
    #2 rst = 1'b1;
    #1;
    chk("arst_pc", pc_out, RST_PC);
    chk("arst_valid", inst_valid, 32'd0);
    chk("arst_req", imem_req, 32'd0);
    chk("arst_count", fetch_count, 32'd0);
    chk("arst_mis", misalign_err, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    rv_pct = 100;
    wait_grant("arst_restart", RST_PC, 1'b0);
    wait_hold("arst_hold");
    chk("arst_ipc", inst_pc, RST_PC);
    chk("arst_inst", inst_out, mem_word(RST_PC));

    // random traffic
    gnt_pct = 60;
    rv_pct  = 50;
    for (int i = 0; i < 3000; i++) begin
      inst_ready = ($urandom_range(0, 99) < 70);
      redirect   = ($urandom_range(0, 99) < 4);
      redirect_pc = $urandom;
      if ($urandom_range(0, 7) != 0) redirect_pc[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) redirect_pc[31:8] = 24'hFFFFFF;
      cyc();
    end
    redirect = 1'b0;
    chk("rand_progress", (m_count >= 150) ? 32'd1 : 32'd0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter and instruction-fetch controller for the single-issue core.
- Drives the current PC into the registered 32-bit PC incrementer and consumes its pc+4 result to form the sequential next PC.
- Issues requests to instruction memory and buffers one fetched instruction toward decode with a valid/ready handshake.
- Applies branch/jump redirects, drops stale in-flight fetches on redirect, and counts retired fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- CNT_W, 32, width of the fetch counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pc_out  out  32  current PC; feeds the incrementer operand_1 and is also imem_addr.
- pc_inc_in  in  32  incrementer result (pc_out+4, one clk behind pc_out).
- imem_req  out  1  fetch request; addr=pc_out.
- imem_gnt  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- inst_out  out  32  buffered instruction.
- inst_pc  out  32  PC of inst_out.
- inst_valid  out  1  inst_out valid to decode.
- inst_ready  in  1  decode accepts when inst_valid&&inst_ready.
- redirect  in  1  single-cycle pulse: take redirect_pc.
- redirect_pc  in  32  branch/jump target.
- misalign_err  out  1  sticky: a redirect target had nonzero bits [1:0].
- fetch_count  out  CNT_W  count of accepted instructions; wraps modulo 2^CNT_W.

Behaviour:
- Reset values (async assert):
  - pc_out=RESET_PC, state=SETTLE, imem_req=0, inst_valid=0.
  - inst_out=0, inst_pc=0, misalign_err=0, fetch_count=0, redir_pend=0.
- States:
  - SETTLE: one cycle, always → REQ. Gives the incrementer one edge to capture pc_out.
  - REQ: imem_req=1. On imem_gnt → WAIT.
  - WAIT: imem_req=0. On imem_rvalid: if no redirect is pending or arriving, capture imem_rdata→inst_out and pc_out→inst_pc, then → HOLD. Otherwise drop the data and → REDIR.
  - HOLD: inst_valid=1. On inst_valid&&inst_ready: fetch_count+=1, then:
    - if redirect or redir_pend: pc_out=target, clear redir_pend;
    - else pc_out=pc_inc_in;
    - → SETTLE.
  - REDIR: pc_out=latched target, clear redir_pend, → SETTLE.
- Redirect capture:
  - A redirect in any state latches redirect_pc into redir_tgt and sets redir_pend.
  - A redirect in the same cycle as the HOLD handshake is applied directly; that redirect wins over pc_inc_in.
  - A redirect in REQ leaves the request standing. The response is then dropped in WAIT.
  - A second redirect before application overwrites redir_tgt; the last one wins.
- Misalignment: a redirect with redirect_pc[1:0]!=0 sets misalign_err until rst. The target is still used with [1:0] forced to 0.
- Sequential PC: pc_inc_in is sampled only in HOLD. At that point pc_out has been stable for ≥2 edges, so pc_inc_in==pc_out+4. 0xFFFF_FFFC+4 wraps to 0 (no carry out).
- Latency: with gnt and rvalid each asserted on the first eligible cycle and ready=1, there is 1 instruction per 4 cycles (SETTLE, REQ, WAIT, HOLD).
- Output stability: inst_out, inst_pc and inst_valid are held unchanged while inst_valid&&!inst_ready.
- Unexpected rvalid: imem_rvalid outside WAIT is ignored.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight memory response after deassertion is ignored unless state is WAIT.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum {SETTLE, REQ, WAIT, HOLD, REDIR};
  - WORD_W=32 and PC_ALIGN_MASK=32'hFFFF_FFFC.
- No sub-module. The incrementer stays external and is instantiated alongside this block at top level.

Test Plan:
- Reset and sequential fetch: RESET_PC=0x100, memory returns 0xAAAA0000+addr, gnt/rvalid immediate, ready=1 → imem addresses 0x100, 0x104, 0x108; inst_pc matches; fetch_count=3 after 12 cycles.
- Backpressure: hold inst_ready=0 for 5 cycles in HOLD at pc 0x104 → inst_out and inst_pc stable, no new imem_req, fetch_count unchanged. Then ready=1 → next address 0x108.
- Redirect with handshake: redirect=1, redirect_pc=0x2000 in the HOLD cycle where ready=1 → next imem_addr=0x2000, not pc+4.
- Redirect during WAIT: redirect_pc=0x3000 while awaiting rvalid → response dropped, inst_valid never asserted for the old PC, next request addr=0x3000.
- Misaligned target and wrap:
  - redirect_pc=0x4002 → misalign_err=1 (sticky), fetch from 0x4000;
  - redirect to 0xFFFF_FFFC → following sequential fetch addr=0x0.
- Async reset mid-WAIT: assert rst between edges → pc_out=RESET_PC, inst_valid=0 immediately. A late rvalid after deassert is ignored; fetch restarts at RESET_PC.
